// File: rtl/mux_scan_n.sv
// N-channel registered selector with a manual single-shot mode and an auto-scan mode.
// Optional parity output is compiled in with MUX_SCAN_PAR_EN.
module mux_scan_n #(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 8,
    parameter int unsigned SW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  d,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    input  logic            start,
    input  logic            out_ready,
    output logic [W-1:0]    q,
    output logic [SW-1:0]   ch,
    output logic            out_valid,
    output logic            busy,
    output logic            err
`ifdef MUX_SCAN_PAR_EN
    ,
    output logic            par
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    q_nx;
    logic [SW-1:0]   ch_nx;
    logic            out_valid_nx;
    logic            err_nx;
    logic [SW-1:0]   ch_inc_c;
    logic            sel_ok_c;

    // Channel picker; indices at or beyond N yield zero.
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] dv, input logic [SW-1:0] idx);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (idx == SW'(k)) r = dv[k*W +: W];
        end
        return r;
    endfunction

    assign ch_inc_c = ch + SW'(1);
    assign sel_ok_c = (32'(sel) < N);

    // Next-state and next-output logic.
    always_comb begin
        state_nx     = state;
        q_nx         = q;
        ch_nx        = ch;
        out_valid_nx = out_valid;
        err_nx       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    out_valid_nx = 1'b1;
                    if (mode) begin
                        state_nx = SCAN;
                        ch_nx    = '0;
                        q_nx     = pick(d, SW'(0));
                    end else begin
                        state_nx = HOLD;
                        ch_nx    = sel;
                        q_nx     = sel_ok_c ? pick(d, sel) : '0;
                        err_nx   = ~sel_ok_c;
                    end
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    out_valid_nx = 1'b0;
                    state_nx     = IDLE;
                end
            end
            SCAN: begin
                if (out_valid && out_ready) begin
                    // Last channel ends the scan without wrapping.
                    if (32'(ch) == N - 1) begin
                        out_valid_nx = 1'b0;
                        state_nx     = IDLE;
                    end else begin
                        ch_nx = ch_inc_c;
                        q_nx  = pick(d, ch_inc_c);
                    end
                end
            end
            default: begin
                state_nx     = IDLE;
                out_valid_nx = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            q         <= '0;
            ch        <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            q         <= q_nx;
            ch        <= ch_nx;
            out_valid <= out_valid_nx;
            busy      <= (state_nx != IDLE);
            err       <= err_nx;
        end
    end

`ifdef MUX_SCAN_PAR_EN
    // Parity tracks q exactly, so it holds whenever q holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par <= 1'b0;
        else        par <= ^q_nx;
    end
`endif

endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n: stimulus pushes expected transfers, monitors pop on handshakes.
// Two instances: N=8 for the main function, N=6 for the out-of-range select case.
module tb_mux_scan_n;

    typedef struct {
        logic [7:0] q;
        logic [2:0] ch;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [2:0]  sel;
    logic        start8, start6;
    logic        rdy8, rdy6;
    logic [63:0] d8;
    logic [47:0] d6;
    logic [7:0]  q8, q6;
    logic [2:0]  ch8, ch6;
    logic        ov8, ov6, busy8, busy6, err8, err6;
`ifdef MUX_SCAN_PAR_EN
    logic        par8, par6;
`endif

    exp_t sb8[$];
    exp_t sb6[$];
    int   total = 0;
    int   bad   = 0;

    mux_scan_n #(.W(8), .N(8), .SW(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .d(d8), .sel(sel), .mode(mode), .start(start8),
        .out_ready(rdy8), .q(q8), .ch(ch8), .out_valid(ov8), .busy(busy8), .err(err8)
`ifdef MUX_SCAN_PAR_EN
        , .par(par8)
`endif
    );

    mux_scan_n #(.W(8), .N(6), .SW(3)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .d(d6), .sel(sel), .mode(mode), .start(start6),
        .out_ready(rdy6), .q(q6), .ch(ch6), .out_valid(ov6), .busy(busy6), .err(err6)
`ifdef MUX_SCAN_PAR_EN
        , .par(par6)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d8(input logic [7:0] base);
        for (int k = 0; k < 8; k++) d8[k*8 +: 8] = 8'(base + 8'(k));
    endtask

    task automatic push8(input logic [7:0] qv, input logic [2:0] cv);
        exp_t e;
        e.q  = qv;
        e.ch = cv;
        sb8.push_back(e);
    endtask

    task automatic wait_idle8();
        int n;
        n = 0;
        while (busy8 && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (busy8) begin
            bad++;
            $display("FAIL wait_idle8 got=busy want=idle");
        end
    endtask

    // Monitor for the N=8 instance: a transfer completes on the next edge.
    always @(negedge clk) begin
        if (rst_n && ov8 && rdy8) begin
            total++;
            if (sb8.size() == 0) begin
                bad++;
                $display("FAIL sb8_unexpected got q=%0h ch=%0d want none", q8, ch8);
            end else begin
                exp_t e;
                e = sb8.pop_front();
                if (q8 !== e.q || ch8 !== e.ch) begin
                    bad++;
                    $display("FAIL sb8_xfer got q=%0h ch=%0d want q=%0h ch=%0d", q8, ch8, e.q, e.ch);
                end
`ifdef MUX_SCAN_PAR_EN
                total++;
                if (par8 !== ^e.q) begin
                    bad++;
                    $display("FAIL sb8_par got=%0b want=%0b", par8, ^e.q);
                end
`endif
            end
        end
    end

    // Monitor for the N=6 instance.
    always @(negedge clk) begin
        if (rst_n && ov6 && rdy6) begin
            total++;
            if (sb6.size() == 0) begin
                bad++;
                $display("FAIL sb6_unexpected got q=%0h ch=%0d want none", q6, ch6);
            end else begin
                exp_t e;
                e = sb6.pop_front();
                if (q6 !== e.q || ch6 !== e.ch) begin
                    bad++;
                    $display("FAIL sb6_xfer got q=%0h ch=%0d want q=%0h ch=%0d", q6, ch6, e.q, e.ch);
                end
            end
        end
    end

    initial begin
        exp_t e6;
        rst_n = 1'b1; start8 = 1'b0; start6 = 1'b0; mode = 1'b0; sel = 3'd0;
        rdy8 = 1'b0; rdy6 = 1'b0;
        set_d8(8'h10);
        for (int k = 0; k < 6; k++) d6[k*8 +: 8] = 8'(8'h20 + 8'(k));
        #2 rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_q", 32'(q8), 32'h0);
        chk("rst_ch", 32'(ch8), 32'h0);
        chk("rst_ov", 32'(ov8), 32'h0);
        chk("rst_busy", 32'(busy8), 32'h0);
        chk("rst_err", 32'(err8), 32'h0);
        rst_n = 1'b1;
        tick();

        // Manual single shot, sel=5, consumer always ready.
        push8(8'h15, 3'd5);
        mode = 1'b0; sel = 3'd5; rdy8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("man_busy", 32'(busy8), 32'h1);
        chk("man_ov", 32'(ov8), 32'h1);
        chk("man_q", 32'(q8), 32'h15);
        tick();
        chk("man_ov_clr", 32'(ov8), 32'h0);
        chk("man_busy_clr", 32'(busy8), 32'h0);

        // Auto-scan, back to back.
        for (int k = 0; k < 8; k++) push8(8'(8'h10 + 8'(k)), 3'(k));
        mode = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("scan_ch", 32'(ch8), 32'(k));
            tick();
        end
        chk("scan_last_q", 32'(q8), 32'h17);
        chk("scan_last_ch", 32'(ch8), 32'h7);
        tick();
        chk("scan_end_ov", 32'(ov8), 32'h0);
        chk("scan_end_busy", 32'(busy8), 32'h0);

        // Start held high across completion: ignored while busy, taken from next idle cycle.
        push8(8'h13, 3'd3);
        push8(8'h13, 3'd3);
        mode = 1'b0; sel = 3'd3; start8 = 1'b1;
        tick();
        chk("hold_start_busy0", 32'(busy8), 32'h1);
        tick();
        chk("hold_start_idle", 32'(busy8), 32'h0);
        tick();
        chk("hold_start_busy1", 32'(busy8), 32'h1);
        start8 = 1'b0;
        tick();
        chk("hold_start_done", 32'(busy8), 32'h0);

        // Stall at ch=2 while d changes.
        for (int k = 0; k < 3; k++) push8(8'(8'h10 + 8'(k)), 3'(k));
        for (int k = 3; k < 8; k++) push8(8'(8'hA0 + 8'(k)), 3'(k));
        mode = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        chk("stall_at_ch", 32'(ch8), 32'h2);
        rdy8 = 1'b0;
        set_d8(8'hA0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_q", 32'(q8), 32'h12);
            chk("stall_ch", 32'(ch8), 32'h2);
        end
        rdy8 = 1'b1;
        tick();
        chk("stall_adv_ch", 32'(ch8), 32'h3);
        chk("stall_adv_q", 32'(q8), 32'hA3);
        wait_idle8();
        set_d8(8'h10);
        tick();

        // Reset in the middle of a scan at ch=4.
        for (int k = 0; k < 4; k++) push8(8'(8'h10 + 8'(k)), 3'(k));
        mode = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        chk("mid_ch", 32'(ch8), 32'h4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_q", 32'(q8), 32'h0);
        chk("mid_rst_ch", 32'(ch8), 32'h0);
        chk("mid_rst_ov", 32'(ov8), 32'h0);
        chk("mid_rst_busy", 32'(busy8), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(ov8), 32'h0);
        push8(8'h11, 3'd1);
        mode = 1'b0; sel = 3'd1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("post_rst_q", 32'(q8), 32'h11);
        tick();
        chk("post_rst_done", 32'(ov8), 32'h0);

        // Out-of-range select on the N=6 instance.
        e6.q = 8'h00;
        e6.ch = 3'd7;
        sb6.push_back(e6);
        mode = 1'b0; sel = 3'd7; rdy6 = 1'b0; start6 = 1'b1;
        tick();
        start6 = 1'b0;
        chk("oor_err", 32'(err6), 32'h1);
        chk("oor_ov", 32'(ov6), 32'h1);
        chk("oor_q", 32'(q6), 32'h0);
        chk("oor_ch", 32'(ch6), 32'h7);
        tick();
        chk("oor_err_clr", 32'(err6), 32'h0);
        chk("oor_ov_held", 32'(ov6), 32'h1);
        rdy6 = 1'b1;
        tick();
        chk("oor_ov_clr", 32'(ov6), 32'h0);

`ifdef MUX_SCAN_PAR_EN
        // Parity on two values of channel 0.
        d8[7:0] = 8'h07;
        push8(8'h07, 3'd0);
        mode = 1'b0; sel = 3'd0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("par_07", 32'(par8), 32'h1);
        tick();
        d8[7:0] = 8'h03;
        push8(8'h03, 3'd0);
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("par_03", 32'(par8), 32'h0);
        tick();
`endif

        repeat (2) tick();
        chk("sb8_drained", 32'(sb8.size()), 32'h0);
        chk("sb6_drained", 32'(sb6.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_n.md
MUX_SCAN_N -- requirements
Module: mux_scan_n

Interface
REQ-001 SHALL have parameter W, default 8: channel data width in bits (1..32).
REQ-002 SHALL have parameter N, default 8: channel count (2..16).
REQ-003 SHALL have parameter SW, default 3: select width, set so that 2**SW >= N.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port d, input, N*W: flattened channels, channel k at bits [k*W+W-1 : k*W].
REQ-007 SHALL have port sel, input, SW: manual channel select.
REQ-008 SHALL have port mode, input, 1: 0 = manual single-shot, 1 = auto-scan all channels.
REQ-009 SHALL have port start, input, 1: request strobe, level-sampled each cycle.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts q when high with out_valid.
REQ-011 SHALL have port q, output, W: registered selected channel data.
REQ-012 SHALL have port ch, output, SW: registered index of the channel in q.
REQ-013 SHALL have port out_valid, output, 1: q/ch hold a sample not yet accepted.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port err, output, 1: one-cycle pulse on out-of-range manual select.

Function
REQ-016 SHALL implement FSM states IDLE, HOLD (manual) and SCAN (auto).
REQ-017 In IDLE with start=1, SHALL sample mode and sel on the same edge; start SHALL be ignored outside IDLE.
REQ-018 In manual mode, SHALL load q=d[sel], ch=sel, out_valid=1 on the start edge, then go to HOLD; latency is 1 cycle.
REQ-019 In HOLD, SHALL keep q/ch/out_valid stable until the out_valid&&out_ready edge, then clear out_valid and return to IDLE.
REQ-020 In auto mode, SHALL load channel 0 on the start edge, go to SCAN, and advance ch by 1 on each accepted transfer, loading q=d[ch+1] on that same edge.
REQ-021 In SCAN, when channel N-1 is accepted, SHALL clear out_valid and return to IDLE; no wrap to channel 0.
REQ-022 When out_valid=1 and out_ready=0 (stall), q and ch SHALL be held and d changes SHALL be ignored.
REQ-023 In manual mode with sel>=N, SHALL load q=0, ch=sel, out_valid=1, and pulse err for exactly one cycle.
REQ-024 Back-to-back operation: with out_ready held high, auto-scan SHALL deliver one channel per cycle, N cycles total.
REQ-025 A start asserted on the cycle busy falls SHALL be ignored; a new request is accepted from the following IDLE cycle.
REQ-026 Capture SHALL use d at the capture edge only; q SHALL never be combinationally dependent on d.

Reset
REQ-027 When rst_n=0, SHALL immediately set state=IDLE, q=0, ch=0, out_valid=0, busy=0, err=0 (and par=0 when compiled in).
REQ-028 Reset mid-operation SHALL abandon the operation with no output on release; the first start after release SHALL behave as from power-up.

Configuration
REQ-029 With macro MUX_SCAN_PAR_EN defined, SHALL add output port par (1 bit) = XOR of all bits of q, registered with q and held under stall.
REQ-030 Without MUX_SCAN_PAR_EN, port par and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 With W=8, N=8, channel k = 8'h10+k, mode=0, sel=5, start pulse, out_ready=1: next edge q=8'h15, ch=5, out_valid for 1 cycle, busy high for 1 cycle.
REQ-032 Under the same setup with mode=1 and out_ready=1: q = 8'h10..8'h17 on 8 consecutive cycles, ch=0..7, then out_valid=0 and busy=0.
REQ-033 During auto-scan with out_ready=0 for 3 cycles at ch=2, and d changed meanwhile: q stays 8'h12 and ch stays 2; advances to ch=3 after out_ready=1.
REQ-034 With N=6, mode=0, sel=7: q=0, ch=7, err pulse for 1 cycle, out_valid=1 until accepted.
REQ-035 With rst_n=0 asserted at ch=4 mid-scan: all outputs 0 immediately; after release, a manual start with sel=1 gives q=8'h11.
REQ-036 With MUX_SCAN_PAR_EN defined, d0=8'h07: par=1 with q=8'h07; with d0=8'h03: par=0.
